// File: rtl/fm_meas_pkg.sv
// Shared widths, constants and FSM state type for the FM parameter meter.
package fm_meas_pkg;

    localparam int SAMPLE_W    = 10;
    localparam int OUT_W       = 8;
    localparam int NUM_W       = 16;
    localparam int X_W         = SAMPLE_W + 1;
    localparam int ZERO_OFFSET = 512;
    localparam int MF_SCALE    = 100;

    typedef enum logic [1:0] {
        MEASURE = 2'd0,
        SCALE   = 2'd1,
        DIVIDE  = 2'd2,
        PUBLISH = 2'd3
    } meas_state_t;

    // Clamp a 16-bit unsigned value into the 8-bit output range.
    function automatic logic [OUT_W-1:0] sat_out(input logic [NUM_W-1:0] v);
        return (|v[NUM_W-1:OUT_W]) ? {OUT_W{1'b1}} : v[OUT_W-1:0];
    endfunction

endpackage

// File: rtl/fm_div.sv
// Sequential restoring divider: 16-bit numerator / 8-bit nonzero denominator.
// The start cycle performs the first iteration, so the 16th iteration lands
// 15 cycles later and done is high in the cycle after it.
module fm_div
    import fm_meas_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NUM_W-1:0] num,
    input  logic [OUT_W-1:0] den,
    output logic             busy,
    output logic             done,
    output logic [NUM_W-1:0] quot
);

    logic [OUT_W:0]   rem_q;
    logic [NUM_W-1:0] quo_q;
    logic [3:0]       iter_q;

    logic [OUT_W:0]   src_rem;
    logic [NUM_W-1:0] src_quo;
    logic [OUT_W+1:0] trial;
    logic [OUT_W+1:0] diff;
    logic [OUT_W:0]   step_rem;
    logic [NUM_W-1:0] step_quo;

    // One restoring step; a fresh division starts from remainder 0 and the raw numerator.
    always_comb begin
        src_rem  = rem_q;
        src_quo  = quo_q;
        if (!busy) begin
            src_rem = '0;
            src_quo = num;
        end
        trial    = {src_rem, src_quo[NUM_W-1]};
        diff     = trial - {2'b00, den};
        step_quo = {src_quo[NUM_W-2:0], 1'b0};
        step_rem = trial[OUT_W:0];
        if (trial >= {2'b00, den}) begin
            step_rem    = diff[OUT_W:0];
            step_quo[0] = 1'b1;
        end
    end

    // Iteration register; a start while busy is ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            iter_q <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (busy) begin
                rem_q  <= step_rem;
                quo_q  <= step_quo;
                iter_q <= iter_q - 4'd1;
                if (iter_q == 4'd1) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end else if (start) begin
                rem_q  <= step_rem;
                quo_q  <= step_quo;
                iter_q <= 4'd15;
                busy   <= 1'b1;
            end
        end
    end

    assign quot = quo_q;

endmodule

// File: rtl/fm_param_meter.sv
// FM parameter meter: per gate window measures modulating frequency
// (zero crossings), peak deviation (half peak-to-peak) and modulation index.
//
// state   | meaning
// MEASURE | accumulate max/min and hysteretic zero crossings over the gate
// SCALE   | convert amplitude to kHz deviation, latch crossing count
// DIVIDE  | mf = delta_f*100 / mod_freq via fm_div
// PUBLISH | register outputs, pulse meas_valid, rearm the window
module fm_param_meter
    import fm_meas_pkg::*;
#(
    parameter int GATE_CYCLES = 1_000_000,
    parameter int HYST        = 8,
    parameter int KDEV_Q8     = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                in_valid,
    input  logic [SAMPLE_W-1:0] demod_in,
    output logic [OUT_W-1:0]    mod_freq,
    output logic [OUT_W-1:0]    delta_f,
    output logic [OUT_W-1:0]    mf,
    output logic                meas_valid
);

    localparam int CNT_W  = $clog2(GATE_CYCLES + 1);
    localparam int PROD_W = SAMPLE_W + 9;
    localparam logic signed [X_W-1:0] HYST_POS = X_W'(HYST);
    localparam logic signed [X_W-1:0] HYST_NEG = -HYST_POS;

    meas_state_t state_q, state_d;

    logic [CNT_W-1:0]      cnt_q;
    logic [OUT_W-1:0]      cross_q;
    logic                  arm_q;
    logic                  first_q;
    logic signed [X_W-1:0] max_q, min_q;
    logic signed [X_W-1:0] x;
    logic                  win_end;

    logic [X_W:0]          span;
    logic [PROD_W-1:0]     prod;
    logic [OUT_W-1:0]      df_calc;
    logic [OUT_W-1:0]      df_q, fm_q;

    logic                  div_started_q;
    logic                  div_start, div_busy, div_done;
    logic [NUM_W-1:0]      div_num, div_quot;

    assign x       = $signed({1'b0, demod_in}) - $signed(X_W'(ZERO_OFFSET));
    assign win_end = (cnt_q == CNT_W'(GATE_CYCLES - 1));

    // Amplitude to deviation; an empty window reads as zero amplitude.
    always_comb begin
        span    = first_q ? '0 : ({max_q[X_W-1], max_q} - {min_q[X_W-1], min_q});
        prod    = PROD_W'(span >> 1) * PROD_W'(KDEV_Q8);
        df_calc = sat_out(NUM_W'(prod >> 8));
    end

    assign div_num = NUM_W'(df_q) * NUM_W'(MF_SCALE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= MEASURE;
        else     state_q <= state_d;
    end

    // Next state and divider start; en low aborts everything back to MEASURE.
    always_comb begin
        state_d   = state_q;
        div_start = 1'b0;
        if (!en) begin
            state_d = MEASURE;
        end else begin
            case (state_q)
                MEASURE: if (win_end) state_d = SCALE;
                SCALE:   state_d = (cross_q == '0) ? PUBLISH : DIVIDE;
                DIVIDE: begin
                    div_start = !div_started_q && !div_busy;
                    if (div_started_q && div_done) state_d = PUBLISH;
                end
                PUBLISH: state_d = MEASURE;
                default: state_d = MEASURE;
            endcase
        end
    end

    // Window accumulation: counter, extremes and hysteretic crossing count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            cross_q <= '0;
            arm_q   <= 1'b0;
            first_q <= 1'b1;
            max_q   <= '0;
            min_q   <= '0;
        end else if (!en || state_q == PUBLISH) begin
            cnt_q   <= '0;
            cross_q <= '0;
            arm_q   <= 1'b0;
            first_q <= 1'b1;
        end else if (state_q == MEASURE) begin
            cnt_q <= cnt_q + 1'b1;
            if (in_valid) begin
                if (first_q) begin
                    max_q   <= x;
                    min_q   <= x;
                    first_q <= 1'b0;
                end else begin
                    if (x > max_q) max_q <= x;
                    if (x < min_q) min_q <= x;
                end
                if (x < HYST_NEG) begin
                    arm_q <= 1'b1;
                end else if (x > HYST_POS && arm_q) begin
                    arm_q <= 1'b0;
                    if (cross_q != '1) cross_q <= cross_q + 1'b1;
                end
            end
        end
    end

    // Latch the scaled results and track whether this DIVIDE visit has launched the divider.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            df_q          <= '0;
            fm_q          <= '0;
            div_started_q <= 1'b0;
        end else begin
            div_started_q <= en && (state_q == DIVIDE);
            if (en && state_q == SCALE) begin
                df_q <= df_calc;
                fm_q <= cross_q;
            end
        end
    end

    fm_div u_div (
        .clk   (clk),
        .rst   (rst),
        .start (div_start),
        .num   (div_num),
        .den   (fm_q),
        .busy  (div_busy),
        .done  (div_done),
        .quot  (div_quot)
    );

    // Output registers update only on a completed, still-enabled PUBLISH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mod_freq   <= '0;
            delta_f    <= '0;
            mf         <= '0;
            meas_valid <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (en && state_q == PUBLISH) begin
                mod_freq   <= fm_q;
                delta_f    <= df_q;
                mf         <= (fm_q == '0) ? '0 : sat_out(div_quot);
                meas_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fm_param_meter.sv
// Self-checking bench for fm_param_meter with a window-level reference model.
module tb_fm_param_meter;

    localparam int  G      = 1000;
    localparam int  HYST   = 8;
    localparam int  KDEV   = 32;
    localparam real TWO_PI = 6.283185307179586;

    logic       clk = 1'b0;
    logic       rst, en, in_valid;
    logic [9:0] demod_in;
    logic [7:0] mod_freq, delta_f, mf;
    logic       meas_valid;

    int  errors = 0;
    int  checks = 0;
    int  win[$];
    int  gt;
    real sig_a, sig_p, sig_ph;
    int  sig_noise;
    bit  gap_junk;
    int  exp_fm, exp_df, exp_mf, exp_lat;
    int  sv_fm, sv_df, sv_mf;
    int  mv_seen;

    fm_param_meter #(.GATE_CYCLES(G), .HYST(HYST), .KDEV_Q8(KDEV)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .in_valid   (in_valid),
        .demod_in   (demod_in),
        .mod_freq   (mod_freq),
        .delta_f    (delta_f),
        .mf         (mf),
        .meas_valid (meas_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int gen_sample();
        real v;
        int  x;
        v = sig_a * $sin(TWO_PI * real'(gt) / sig_p + sig_ph);
        x = int'(v);
        if (sig_noise > 0) x += int'($urandom_range(0, 2 * sig_noise)) - sig_noise;
        if (x > 511)  x = 511;
        if (x < -512) x = -512;
        return x;
    endfunction

    // Window result straight from the measurement rules.
    task automatic model();
        int mx, mn, cr, amp;
        bit arm;
        mx = 0; mn = 0; cr = 0; arm = 0;
        foreach (win[i]) begin
            if (i == 0) begin mx = win[i]; mn = win[i]; end
            if (win[i] > mx) mx = win[i];
            if (win[i] < mn) mn = win[i];
            if (win[i] < -HYST) arm = 1;
            else if (win[i] > HYST && arm) begin cr++; arm = 0; end
        end
        exp_fm = (cr > 255) ? 255 : cr;
        amp    = (mx - mn) / 2;
        exp_df = (amp * KDEV) / 256;
        if (exp_df > 255) exp_df = 255;
        if (exp_fm == 0) exp_mf = 0;
        else begin
            exp_mf = (exp_df * 100) / exp_fm;
            if (exp_mf > 255) exp_mf = 255;
        end
        exp_lat = (exp_fm == 0) ? 2 : 19;
    endtask

    task automatic drive_sample(input bit keep);
        int x;
        x = gen_sample();
        if (keep) win.push_back(x);
        if (!keep && gap_junk) demod_in = 10'($urandom_range(0, 1023));
        else                   demod_in = 10'(x + 512);
        in_valid = 1'b1;
        gt++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_window();
        win.delete();
        for (int i = 0; i < G; i++) begin
            drive_sample(1'b1);
            if (i == 0) chk("mv_pulse_len", meas_valid, 0);
        end
    endtask

    task automatic await_result(input string tag);
        int n;
        model();
        n = 0;
        while (meas_valid !== 1'b1 && n < 40) begin
            drive_sample(1'b0);
            n++;
        end
        chk({tag, "_latency"}, n, exp_lat);
        chk({tag, "_mod_freq"}, mod_freq, exp_fm);
        chk({tag, "_delta_f"}, delta_f, exp_df);
        chk({tag, "_mf"}, mf, exp_mf);
    endtask

    task automatic set_sig(input real a, input real p, input real ph, input int noise, input bit junk);
        sig_a = a; sig_p = p; sig_ph = ph; sig_noise = noise; gap_junk = junk;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; in_valid = 1'b0; demod_in = 10'd512; gt = 0;
        set_sig(0.0, 100.0, 0.0, 0, 1'b0);
        #12;
        chk("rst_mod_freq", mod_freq, 0);
        chk("rst_delta_f", delta_f, 0);
        chk("rst_mf", mf, 0);
        chk("rst_meas_valid", meas_valid, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Sine, period 100, amplitude 200, negative half first
        set_sig(-200.0, 100.0, 0.0, 0, 1'b0);
        gt = 0;
        run_window();
        await_result("sine100");
        chk("sine100_lat_lit", exp_lat, 19);
        chk("sine100_fm_lit", mod_freq, 10);
        chk("sine100_df_lit", delta_f, 25);
        chk("sine100_mf_lit", mf, 250);

        // Sine, period 200, amplitude 40, two back-to-back windows
        set_sig(-40.0, 200.0, 0.0, 0, 1'b0);
        gt = 0;
        for (int w = 0; w < 2; w++) begin
            run_window();
            await_result("sine200");
            chk("sine200_fm_lit", mod_freq, 5);
            chk("sine200_df_lit", delta_f, 5);
            chk("sine200_mf_lit", mf, 100);
        end

        // Constant mid-scale, then sub-hysteresis noise; junk in the gaps
        set_sig(0.0, 100.0, 0.0, 0, 1'b1);
        run_window();
        await_result("const");
        chk("const_mf_lit", mf, 0);
        set_sig(0.0, 100.0, 0.0, 6, 1'b1);
        run_window();
        await_result("noise6");
        chk("noise6_fm_lit", mod_freq, 0);
        chk("noise6_df_lit", delta_f, 0);

        // Cosine from peak, one crossing, mf saturates
        set_sig(200.0, 1000.0, TWO_PI / 4.0, 0, 1'b0);
        gt = 0;
        run_window();
        await_result("cos1000");
        chk("cos1000_fm_lit", mod_freq, 1);
        chk("cos1000_df_lit", delta_f, 25);
        chk("cos1000_mf_lit", mf, 255);

        // Randomised tones with noise
        for (int r = 0; r < 3; r++) begin
            set_sig(real'($urandom_range(20, 511)) * (($urandom_range(0, 1) == 0) ? 1.0 : -1.0),
                    real'($urandom_range(40, 400)), real'($urandom_range(0, 628)) / 100.0,
                    int'($urandom_range(0, 20)), 1'b1);
            run_window();
            await_result("rand");
        end

        // Reset while dividing clears outputs asynchronously
        set_sig(-200.0, 100.0, 0.0, 0, 1'b0);
        gt = 0;
        run_window();
        for (int i = 0; i < 5; i++) drive_sample(1'b0);
        #2 rst = 1'b1;
        #1;
        chk("rstdiv_mod_freq", mod_freq, 0);
        chk("rstdiv_delta_f", delta_f, 0);
        chk("rstdiv_mf", mf, 0);
        chk("rstdiv_meas_valid", meas_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        set_sig(-40.0, 200.0, 0.0, 0, 1'b0);
        gt = 0;
        run_window();
        await_result("after_rst");

        // Drop en while dividing: no pulse, outputs hold, then a fresh window
        sv_fm = exp_fm; sv_df = exp_df; sv_mf = exp_mf;
        set_sig(-200.0, 100.0, 0.0, 0, 1'b1);
        run_window();
        for (int i = 0; i < 5; i++) drive_sample(1'b0);
        en = 1'b0;
        mv_seen = 0;
        for (int i = 0; i < 30; i++) begin
            drive_sample(1'b0);
            if (meas_valid !== 1'b0) mv_seen++;
        end
        chk("endrop_no_pulse", mv_seen, 0);
        chk("endrop_mod_freq", mod_freq, sv_fm);
        chk("endrop_delta_f", delta_f, sv_df);
        chk("endrop_mf", mf, sv_mf);
        en = 1'b1;
        set_sig(200.0, 1000.0, TWO_PI / 4.0, 0, 1'b0);
        gt = 0;
        run_window();
        await_result("after_en");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fm_param_meter.md
Name: fm_param_meter

Overview:
- Downstream of the FM demodulator top; consumes its 10-bit offset-binary demodulated audio and the sample strobe.
- Measures three values once per gate window:
  - modulating frequency, by zero-crossing count;
  - peak frequency deviation, from half peak-to-peak amplitude times a deviation scale;
  - modulation index mf = delta_f / f_mod.
- Drives the mf, delta_f and mod_freq outputs that the demodulator top currently ties to zero.

Parameters:
- GATE_CYCLES, 1_000_000: gate window length in clk cycles (10 ms at 100 MHz); sets mod_freq LSB = 1/gate = 100 Hz.
- HYST, 8: zero-crossing hysteresis in LSBs of the signed sample.
- KDEV_Q8, 32: deviation scale, kHz per amplitude LSB, Q0.8 (32 = 0.125 kHz/LSB).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- en  in  1  measurement enable
- in_valid  in  1  sample strobe (demodulator FIR output valid)
- demod_in  in  10  demodulated sample, offset binary, 512 = zero
- mod_freq  out  8  modulating frequency, 100 Hz units, saturating
- delta_f  out  8  peak deviation, kHz units, saturating
- mf  out  8  modulation index, 0.1 units, saturating
- meas_valid  out  1  one-cycle pulse when all three outputs update

Behaviour:
- Reset (async, rst=1):
  - all outputs 0, meas_valid 0;
  - FSM goes to MEASURE with window counter 0, crossing count 0, arm flag 0, first-sample flag 1.
- Sample conversion: x = signed(demod_in) - 512, 11-bit signed. Range -512..+511.
- FSM states:
  - MEASURE
    - Each en=1 cycle increments the window counter.
    - On in_valid with first-sample flag set: max = min = x, then clear the flag.
    - On later in_valid: update max and min.
    - Arm flag sets when x < -HYST.
    - When x > +HYST with arm set: crossing count increments (saturates at 255) and arm clears.
    - When the counter reaches GATE_CYCLES-1: a sample present that same cycle is included, then go to SCALE.
  - SCALE (1 cycle)
    - amp = (max - min) >>> 1, unsigned 0..511.
    - prod = amp * KDEV_Q8; df = prod >> 8, saturated to 255.
    - fm = crossing count.
    - If fm == 0, skip to PUBLISH with mf = 0; else go to DIVIDE.
  - DIVIDE
    - Start fm_div with num = df*100 (16-bit) and den = fm.
    - Wait for its done pulse; quotient saturates to 255.
  - PUBLISH (1 cycle)
    - Register mod_freq = fm, delta_f = df, mf = quotient.
    - Pulse meas_valid.
    - Clear counter, crossing count and arm; set first-sample flag.
    - Return to MEASURE.
- Sampling outside MEASURE: samples arriving during SCALE, DIVIDE or PUBLISH are ignored. That is ≤ 20 cycles per window, which is negligible.
- en=0:
  - forces MEASURE and clears counter, crossings, arm and first-sample state;
  - aborts any computation in progress (divider start suppressed, its result discarded);
  - outputs hold their last values and meas_valid stays 0.
- Empty window: if no sample arrived in the window, max = min = 0, so delta_f = 0.
- Latency: window end to meas_valid pulse = 1 (SCALE) + 17 (DIVIDE) + 1 (PUBLISH) = 19 cycles. The fm==0 path takes 2 cycles.

Decomposition:
- Shared package fm_meas_pkg holds:
  - widths SAMPLE_W=10, OUT_W=8, NUM_W=16;
  - ZERO_OFFSET = 512;
  - constant MF_SCALE = 100;
  - FSM state enum {MEASURE, SCALE, DIVIDE, PUBLISH}.
- Sub-module fm_div: sequential restoring divider, 16-bit unsigned numerator, 8-bit nonzero denominator, 16-bit quotient.
  - Ports: clk, rst, start, num, den, busy, done, quot.
  - 16 iterations, done 1 cycle after the last iteration.
  - start while busy is ignored.

Test Plan (GATE_CYCLES=1000, HYST=8, KDEV_Q8=32, in_valid every cycle):
- Sine, period 100, amplitude 200, centred 512 -> meas_valid after 1019 cycles; mod_freq=10, delta_f=25, mf=250.
- Sine, period 200, amplitude 40 -> mod_freq=5, delta_f=5, mf=100; consecutive windows give identical results.
- Constant 512; then ±6 LSB noise around 512 (below hysteresis) -> mod_freq=0, delta_f=0, mf=0, meas_valid still pulses each window.
- Cosine, period 1000, amplitude 200, starting at peak -> mod_freq=1, delta_f=25, mf saturates to 255.
- Assert rst during DIVIDE -> outputs 0 asynchronously; the next window yields a correct result.
- Drop en during DIVIDE -> no meas_valid pulse and outputs hold their prior values. Raise en -> the next result follows a full fresh window.
